// File: rtl/mem_access_stage_pkg.sv
// Shared widths, load/store opcode and FSM encodings for the MEM stage.
package mem_access_stage_pkg;

   localparam int MAS_DATA_W = 32;
   localparam int MAS_REG_AW = 5;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LH   = 4'd2,
      OP_LW   = 4'd3,
      OP_LBU  = 4'd4,
      OP_LHU  = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_ACK = 1'b1
   } state_e;

   function automatic logic op_is_load(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd5);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op >= 4'd6) && (op <= 4'd8);
   endfunction

   // Undefined opcodes decode as NONE, so they are always "aligned".
   function automatic logic op_aligned(input logic [3:0] op, input logic [1:0] off);
      case (op)
         OP_LH, OP_LHU, OP_SH: return ~off[0];
         OP_LW, OP_SW:         return (off == 2'b00);
         default:              return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// Combinational load-data extraction: byte/half lane select plus sign or zero extension.
module load_formatter
   import mem_access_stage_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (op)
         OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data = {24'h0, byte_sel};
         OP_LH:   data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data = {16'h0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one handshaked data-memory access per load/store, registered write-back.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_W = MAS_DATA_W,
   parameter int REG_AW = MAS_REG_AW
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ex_valid,
   input  logic              ex_wreg,
   input  logic [REG_AW-1:0] ex_waddr,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [3:0]        ex_mem_op,
   input  logic [DATA_W-1:0] ex_store_data,
   output logic              stall_req,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              misalign_err,
   output logic              wb_write_op,
   output logic [REG_AW-1:0] wb_write_addr,
   output logic [DATA_W-1:0] wb_write_data
);

   state_e            state, state_next;
   logic [3:0]        op_q;
   logic [1:0]        off_q;
   logic [REG_AW-1:0] waddr_q;
   logic              wreg_q;
   logic [DATA_W-1:0] load_data;
   logic              ex_mem, ex_ok, accept;
   logic [DATA_W-1:0] st_wdata;
   logic [3:0]        st_wmask;

   assign ex_mem = op_is_load(ex_mem_op) | op_is_store(ex_mem_op);
   assign ex_ok  = op_aligned(ex_mem_op, ex_alu_result[1:0]);
   assign accept = (state == ST_IDLE) & ex_valid & ex_mem & ex_ok;

   always_comb begin
      st_wdata = ex_store_data;
      st_wmask = 4'b0000;
      case (ex_mem_op)
         OP_SB: begin
            st_wdata = {4{ex_store_data[7:0]}};
            st_wmask = 4'b0001 << ex_alu_result[1:0];
         end
         OP_SH: begin
            st_wdata = {2{ex_store_data[15:0]}};
            st_wmask = 4'b0011 << ex_alu_result[1:0];
         end
         OP_SW:   st_wmask = 4'b1111;
         default: ;
      endcase
   end

   load_formatter u_fmt (
      .op     (op_q),
      .offset (off_q),
      .rdata  (mem_rdata),
      .data   (load_data)
   );

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:     if (accept)  state_next = ST_WAIT_ACK;
         ST_WAIT_ACK: if (mem_ack) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // Zero-wait acks release upstream in the same cycle the request is seen.
   always_comb begin
      stall_req = 1'b0;
      case (state)
         ST_IDLE:     stall_req = accept;
         ST_WAIT_ACK: stall_req = ~mem_ack;
         default:     stall_req = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_wmask     <= 4'b0000;
         misalign_err  <= 1'b0;
         wb_write_op   <= 1'b0;
         wb_write_addr <= '0;
         wb_write_data <= '0;
         op_q          <= 4'd0;
         off_q         <= 2'd0;
         waddr_q       <= '0;
         wreg_q        <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         wb_write_op  <= 1'b0;
         if (state == ST_IDLE) begin
            if (ex_valid && !ex_mem) begin
               wb_write_op   <= ex_wreg & (ex_waddr != '0);
               wb_write_addr <= ex_waddr;
               wb_write_data <= ex_alu_result;
            end else if (ex_valid && !ex_ok) begin
               misalign_err <= 1'b1;
            end else if (accept) begin
               mem_req   <= 1'b1;
               mem_we    <= op_is_store(ex_mem_op);
               mem_addr  <= {ex_alu_result[DATA_W-1:2], 2'b00};
               mem_wdata <= st_wdata;
               mem_wmask <= st_wmask;
               op_q      <= ex_mem_op;
               off_q     <= ex_alu_result[1:0];
               waddr_q   <= ex_waddr;
               wreg_q    <= ex_wreg;
            end
         end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (op_is_load(op_q)) begin
               wb_write_op   <= wreg_q & (waddr_q != '0);
               wb_write_addr <= waddr_q;
               wb_write_data <= load_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a write-back scoreboard.
module tb_mem_access_stage;

   localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                          LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ex_valid = 1'b0, ex_wreg = 1'b0;
   logic [4:0]  ex_waddr = '0;
   logic [31:0] ex_alu_result = '0, ex_store_data = '0;
   logic [3:0]  ex_mem_op = '0;
   logic        stall_req, mem_req, mem_we, misalign_err, wb_write_op;
   logic [31:0] mem_addr, mem_wdata, wb_write_data;
   logic [3:0]  mem_wmask;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [4:0]  wb_write_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_exp_t;
   wb_exp_t sb[$];

   always #5 CLK = ~CLK;

   mem_access_stage dut (
      .CLK(CLK), .RST(RST),
      .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
      .ex_alu_result(ex_alu_result), .ex_mem_op(ex_mem_op), .ex_store_data(ex_store_data),
      .stall_req(stall_req), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .misalign_err(misalign_err), .wb_write_op(wb_write_op),
      .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data)
   );

   // Every register-file write must match the oldest expected write.
   always @(negedge CLK) begin
      if (!RST && wb_write_op) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: write x%0d=%h, none expected", wb_write_addr, wb_write_data);
         end else begin
            wb_exp_t e;
            e = sb.pop_front();
            if (wb_write_addr !== e.addr || wb_write_data !== e.data) begin
               errors++;
               $display("FAIL sb_write: got x%0d=%h, expected x%0d=%h",
                        wb_write_addr, wb_write_data, e.addr, e.data);
            end
         end
      end
   end

   function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [1:0] o,
                                            input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[8*o +: 8];
      h = rd[16*o[1] +: 16];
      case (op)
         LB:      return {{24{b[7]}}, b};
         LBU:     return {24'h0, b};
         LH:      return {{16{h[15]}}, h};
         LHU:     return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] sd);
      case (op)
         SB:      return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
         SH:      return {sd[15:0], sd[15:0]};
         default: return sd;
      endcase
   endfunction

   function automatic logic [3:0] exp_wmask(input logic [3:0] op, input logic [1:0] o);
      case (op)
         SB:      return 4'(1 << o);
         SH:      return o[1] ? 4'b1100 : 4'b0011;
         SW:      return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic step();
      @(posedge CLK); #1;
   endtask

   // Runs one memory op with a fixed number of wait cycles; returns what was observed.
   task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] waddr, input logic wreg, input logic [31:0] rdata,
                         input int waits, output int stalls, output int req_bad,
                         output logic [31:0] o_addr, output logic [31:0] o_wdata,
                         output logic [3:0] o_wmask, output logic o_we);
      stalls = 0; req_bad = 0;
      ex_valid = 1'b1; ex_mem_op = op; ex_alu_result = addr; ex_store_data = sd;
      ex_waddr = waddr; ex_wreg = wreg;
      @(negedge CLK);
      if (stall_req) stalls++;
      if (mem_req) req_bad++;
      step();
      for (int i = 0; i < waits; i++) begin
         @(negedge CLK);
         if (stall_req) stalls++;
         if (!mem_req) req_bad++;
         step();
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge CLK);
      if (stall_req) stalls++;
      if (!mem_req) req_bad++;
      o_addr = mem_addr; o_wdata = mem_wdata; o_wmask = mem_wmask; o_we = mem_we;
      step();
      mem_ack = 1'b0; ex_valid = 1'b0;
      @(negedge CLK);
      if (mem_req) req_bad++;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) step();
      @(negedge CLK);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, misalign_err, wb_write_op,
           wb_write_addr, wb_write_data, stall_req} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h mask=%b err=%b wb=%b/%0d/%h",
                  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, misalign_err,
                  wb_write_op, wb_write_addr, wb_write_data);
      end
      step();
      RST = 1'b0;
   endtask

   task automatic test_alu();
      ex_valid = 1'b1; ex_wreg = 1'b1; ex_waddr = 5'd5; ex_alu_result = 32'h1234_5678;
      ex_mem_op = NONE;
      sb.push_back('{5'd5, 32'h1234_5678});
      @(negedge CLK);
      checks++;
      if (stall_req !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b, expected 0", stall_req); end
      step();
      ex_valid = 1'b0;
      @(negedge CLK);
      checks++;
      if (wb_write_op !== 1'b1 || wb_write_addr !== 5'd5 || wb_write_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL alu_wb: got %b/%0d/%h, expected 1/5/12345678", wb_write_op, wb_write_addr, wb_write_data);
      end
      step();
      @(negedge CLK);
      checks++;
      if (wb_write_op !== 1'b0 || wb_write_addr !== 5'd5 || wb_write_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL alu_idle_hold: got %b/%0d/%h, expected 0/5/12345678", wb_write_op, wb_write_addr, wb_write_data);
      end
   endtask

   task automatic test_lb_sign();
      int st, rb; logic [31:0] a, wd; logic [3:0] m; logic we;
      step();
      sb.push_back('{5'd7, 32'hFFFF_FF80});
      do_mem(LB, 32'h103, 32'h0, 5'd7, 1'b1, 32'h80FF_0011, 3, st, rb, a, wd, m, we);
      checks++;
      if (st != 4 || rb != 0 || a !== 32'h100 || we !== 1'b0 || m !== 4'b0000) begin
         errors++;
         $display("FAIL lb_sign: stalls=%0d reqbad=%0d addr=%h we=%b mask=%b, expected 4/0/100/0/0000", st, rb, a, we, m);
      end
   endtask

   task automatic test_sh();
      int st, rb; logic [31:0] a, wd; logic [3:0] m; logic we;
      step();
      do_mem(SH, 32'h202, 32'hAAAA_BEEF, 5'd9, 1'b1, 32'h5555_5555, 1, st, rb, a, wd, m, we);
      checks++;
      if (st != 2 || rb != 0 || a !== 32'h200 || we !== 1'b1 || wd !== 32'hBEEF_BEEF || m !== 4'b1100) begin
         errors++;
         $display("FAIL sh_store: stalls=%0d reqbad=%0d addr=%h we=%b wd=%h mask=%b, expected 2/0/200/1/beefbeef/1100", st, rb, a, we, wd, m);
      end
      checks++;
      if (wb_write_op !== 1'b0) begin errors++; $display("FAIL sh_no_wb: got %b, expected 0", wb_write_op); end
   endtask

   task automatic test_load_table();
      logic [3:0] ops [5] = '{LB, LBU, LH, LHU, LW};
      int st, rb; logic [31:0] a, wd, rd, ad; logic [3:0] m; logic we;
      for (int i = 0; i < 5; i++) begin
         for (int o = 0; o < 4; o++) begin
            if ((ops[i] == LW && o != 0) || ((ops[i] == LH || ops[i] == LHU) && o[0])) continue;
            rd = $urandom() | 32'h8080_8080;
            ad = 32'h1000 + 32'(16 * i) + 32'(o);
            step();
            sb.push_back('{5'(10 + i), exp_load(ops[i], 2'(o), rd)});
            do_mem(ops[i], ad, 32'h0, 5'(10 + i), 1'b1, rd, o % 3, st, rb, a, wd, m, we);
            checks++;
            if (st != (o % 3) + 1 || rb != 0 || a !== {ad[31:2], 2'b00} || we !== 1'b0 || m !== 4'b0000) begin
               errors++;
               $display("FAIL load_req op=%0d o=%0d: stalls=%0d reqbad=%0d addr=%h we=%b mask=%b", ops[i], o, st, rb, a, we, m);
            end
         end
      end
   endtask

   task automatic test_store_table();
      logic [3:0] ops [7] = '{SB, SB, SB, SB, SH, SH, SW};
      logic [1:0] offs [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
      int st, rb; logic [31:0] a, wd, sd, ad; logic [3:0] m; logic we;
      for (int i = 0; i < 7; i++) begin
         sd = $urandom();
         ad = 32'h2000 + 32'(16 * i) + 32'(offs[i]);
         step();
         do_mem(ops[i], ad, sd, 5'd4, 1'b1, 32'h0, 0, st, rb, a, wd, m, we);
         checks++;
         if (st != 1 || rb != 0 || a !== {ad[31:2], 2'b00} || we !== 1'b1 ||
             wd !== exp_wdata(ops[i], sd) || m !== exp_wmask(ops[i], offs[i])) begin
            errors++;
            $display("FAIL store_req op=%0d o=%0d: stalls=%0d addr=%h we=%b wd=%h mask=%b, expected wd=%h mask=%b",
                     ops[i], offs[i], st, a, we, wd, m, exp_wdata(ops[i], sd), exp_wmask(ops[i], offs[i]));
         end
      end
   endtask

   task automatic test_misaligned();
      step();
      ex_valid = 1'b1; ex_wreg = 1'b1; ex_waddr = 5'd6; ex_alu_result = 32'h301; ex_mem_op = LW;
      @(negedge CLK);
      checks++;
      if (stall_req !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b, expected 0", stall_req); end
      step();
      ex_valid = 1'b0;
      @(negedge CLK);
      checks++;
      if (misalign_err !== 1'b1 || mem_req !== 1'b0 || wb_write_op !== 1'b0) begin
         errors++;
         $display("FAIL misalign_pulse: err=%b req=%b wb=%b, expected 1/0/0", misalign_err, mem_req, wb_write_op);
      end
      step();
      @(negedge CLK);
      checks++;
      if (misalign_err !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL misalign_one_cycle: err=%b req=%b, expected 0/0", misalign_err, mem_req);
      end
   endtask

   task automatic test_reset_mid_access();
      step();
      ex_valid = 1'b1; ex_wreg = 1'b1; ex_waddr = 5'd3; ex_alu_result = 32'h400; ex_mem_op = LW;
      step();
      @(negedge CLK);
      checks++;
      if (mem_req !== 1'b1 || stall_req !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: req=%b stall=%b, expected 1/1", mem_req, stall_req);
      end
      step();
      RST = 1'b1; ex_valid = 1'b0;
      step();
      RST = 1'b0;
      @(negedge CLK);
      checks++;
      if (mem_req !== 1'b0 || stall_req !== 1'b0 || mem_addr !== 32'h0 ||
          wb_write_op !== 1'b0 || wb_write_addr !== 5'd0 || wb_write_data !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_clear: req=%b stall=%b addr=%h wb=%b/%0d/%h, expected all 0",
                  mem_req, stall_req, mem_addr, wb_write_op, wb_write_addr, wb_write_data);
      end
      step();
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ack = 1'b0;
      @(negedge CLK);
      checks++;
      if (wb_write_op !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_late_ack: wb=%b req=%b, expected 0/0", wb_write_op, mem_req);
      end
   endtask

   task automatic test_x0_load();
      int st, rb; logic [31:0] a, wd; logic [3:0] m; logic we;
      step();
      do_mem(LW, 32'h500, 32'h0, 5'd0, 1'b1, 32'hDEAD_BEEF, 0, st, rb, a, wd, m, we);
      checks++;
      if (wb_write_op !== 1'b0 || st != 1) begin
         errors++;
         $display("FAIL x0_load: wb=%b stalls=%0d, expected 0/1", wb_write_op, st);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  wa;
      logic        wr;
      logic [31:0] d;
      step();
      for (int i = 0; i < 10; i++) begin
         wa = (i % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wr = (i % 5 != 3);
         d  = $urandom();
         ex_valid = 1'b1; ex_wreg = wr; ex_waddr = wa; ex_alu_result = d; ex_mem_op = (i == 7) ? 4'd12 : NONE;
         if (wr && wa != 5'd0) sb.push_back('{wa, d});
         @(negedge CLK);
         checks++;
         if (stall_req !== 1'b0) begin errors++; $display("FAIL b2b_stall: i=%0d got %b, expected 0", i, stall_req); end
         step();
      end
      ex_valid = 1'b0;
      repeat (2) step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_lb_sign();
      test_sh();
      test_load_table();
      test_store_table();
      test_misaligned();
      test_reset_mid_access();
      test_x0_load();
      test_back_to_back();
      repeat (2) step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected writes never seen, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
